// File: rtl/ctrlport_if_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ctrlport_if_arbiter_pkg
// Description : Shared control-port definitions: response status codes and
//               the request/response structures carried on every ctrlport.
// Revision    : 1.0 - initial release
// ============================================================================
package ctrlport_if_arbiter_pkg;

  // Response status codes
  localparam logic [1:0] C_STS_OKAY   = 2'b00;
  localparam logic [1:0] C_STS_CMDERR = 2'b01;
  localparam logic [1:0] C_STS_TSERR  = 2'b10;
  localparam logic [1:0] C_STS_SLVERR = 2'b11;

  typedef struct packed {
    logic        wr;
    logic        rd;
    logic [19:0] addr;
    logic [31:0] data;
    logic [3:0]  byte_en;
  } ctrlport_req_t;

  typedef struct packed {
    logic        ack;
    logic [1:0]  status;
    logic [31:0] data;
  } ctrlport_resp_t;

endpackage
`default_nettype wire

// File: rtl/ctrlport_rr_grant.sv
`default_nettype none
// ============================================================================
// Module      : ctrlport_rr_grant
// Description : Combinational round-robin picker. Returns the first pending
//               requester found searching upward from last_grant+1, wrapping
//               modulo NUM_PORTS.
// Ports       : pending_i    - request vector
//               last_grant_i - index granted most recently
//               grant_o      - one-hot grant (all zero when nothing pending)
//               grant_idx_o  - binary index of grant_o
//               valid_o      - at least one requester pending
// Revision    : 1.0 - initial release
// ============================================================================
module ctrlport_rr_grant #(
  parameter int NUM_PORTS = 4,
  parameter int IDX_W     = $clog2(NUM_PORTS)
) (
  input  logic [NUM_PORTS-1:0] pending_i,
  input  logic [IDX_W-1:0]     last_grant_i,
  output logic [NUM_PORTS-1:0] grant_o,
  output logic [IDX_W-1:0]     grant_idx_o,
  output logic                 valid_o
);

  int               cand;
  logic [IDX_W-1:0] cand_idx;

  // Walk the search order from farthest to nearest so the nearest pending
  // candidate is the last one written and therefore wins.
  always_comb begin
    grant_o     = '0;
    grant_idx_o = '0;
    cand        = 0;
    cand_idx    = '0;
    for (int k = NUM_PORTS; k >= 1; k--) begin
      cand     = (int'(last_grant_i) + k) % NUM_PORTS;
      cand_idx = IDX_W'(cand);
      if (pending_i[cand_idx]) begin
        grant_o           = '0;
        grant_o[cand_idx] = 1'b1;
        grant_idx_o       = cand_idx;
      end
    end
  end

  assign valid_o = |pending_i;

endmodule
`default_nettype wire

// File: rtl/ctrlport_if_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : ctrlport_if_arbiter
// Description : Round-robin arbiter sharing one downstream control port among
//               NUM_PORTS requesters. Each requester pulse is held until it
//               is issued downstream; the response returns only to the
//               originating port.
// Ports       : ctrlport_clk      - clock
//               ctrlport_rst_n    - asynchronous active-low reset
//               s_ctrlport_req_i  - requester requests (one per port)
//               s_ctrlport_resp_o - requester responses (one per port)
//               m_ctrlport_req_o  - shared downstream request
//               m_ctrlport_resp_i - shared downstream response
//               busy_o            - transaction outstanding downstream
// Options     : CTRLPORT_ARB_TIMEOUT_EN - when defined, a transaction not
//               acknowledged within TIMEOUT cycles completes with SLVERR.
// Revision    : 1.0 - initial release
// ============================================================================
module ctrlport_if_arbiter
  import ctrlport_if_arbiter_pkg::*;
#(
  parameter int NUM_PORTS = 4,
  parameter int TIMEOUT   = 1024
) (
  input  logic                            ctrlport_clk,
  input  logic                            ctrlport_rst_n,
  input  ctrlport_req_t  [NUM_PORTS-1:0]  s_ctrlport_req_i,
  output ctrlport_resp_t [NUM_PORTS-1:0]  s_ctrlport_resp_o,
  output ctrlport_req_t                   m_ctrlport_req_o,
  input  ctrlport_resp_t                  m_ctrlport_resp_i,
  output logic                            busy_o
);

  localparam int IDX_W = $clog2(NUM_PORTS);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } state_t;

  state_t                          state_q;
  logic           [NUM_PORTS-1:0]  pending_q;
  ctrlport_req_t  [NUM_PORTS-1:0]  held_q;
  logic           [IDX_W-1:0]      last_grant_q;
  logic           [IDX_W-1:0]      grant_q;
  logic           [NUM_PORTS-1:0]  grant_oh_q;
  ctrlport_req_t                   m_req_q;
  ctrlport_resp_t [NUM_PORTS-1:0]  s_resp_q;
  logic                            busy_q;

  logic           [NUM_PORTS-1:0]  rr_grant_oh;
  logic           [IDX_W-1:0]      rr_grant_idx;
  logic                            rr_valid;

  // Completion of the outstanding transaction and the response to return
  logic                            done;
  ctrlport_resp_t                  done_resp;

  ctrlport_rr_grant #(
    .NUM_PORTS (NUM_PORTS),
    .IDX_W     (IDX_W)
  ) u_rr_grant (
    .pending_i    (pending_q),
    .last_grant_i (last_grant_q),
    .grant_o      (rr_grant_oh),
    .grant_idx_o  (rr_grant_idx),
    .valid_o      (rr_valid)
  );

`ifdef CTRLPORT_ARB_TIMEOUT_EN
  // Held at zero in IDLE, so the first WAIT cycle counts as cycle 0 and the
  // forced response is registered TIMEOUT cycles after the request pulse.
  logic [15:0] wait_cnt_q;
  logic        expired;

  assign expired = (wait_cnt_q == 16'(TIMEOUT - 1));

  always_ff @(posedge ctrlport_clk or negedge ctrlport_rst_n) begin
    if (!ctrlport_rst_n) begin
      wait_cnt_q <= '0;
    end else if (state_q == S_IDLE) begin
      wait_cnt_q <= '0;
    end else begin
      wait_cnt_q <= wait_cnt_q + 16'd1;
    end
  end

  // A real ack takes precedence over an expiry in the same cycle.
  always_comb begin
    done      = (state_q == S_WAIT) && (m_ctrlport_resp_i.ack || expired);
    done_resp = m_ctrlport_resp_i.ack ? m_ctrlport_resp_i
                                      : '{ack: 1'b1, status: C_STS_SLVERR, data: 32'h0};
  end
`else
  logic unused_timeout;
  assign unused_timeout = ^32'(TIMEOUT);

  always_comb begin
    done      = (state_q == S_WAIT) && m_ctrlport_resp_i.ack;
    done_resp = m_ctrlport_resp_i;
  end
`endif

  always_ff @(posedge ctrlport_clk or negedge ctrlport_rst_n) begin
    if (!ctrlport_rst_n) begin
      state_q      <= S_IDLE;
      pending_q    <= '0;
      held_q       <= '0;
      last_grant_q <= IDX_W'(NUM_PORTS - 1);
      grant_q      <= '0;
      grant_oh_q   <= '0;
      m_req_q      <= '0;
      s_resp_q     <= '0;
      busy_q       <= 1'b0;
    end else begin
      // Responses are single-cycle pulses.
      s_resp_q <= '0;

      // Capture only into an empty holding register; a pulse arriving while
      // one is held is a protocol violation and is dropped.
      for (int i = 0; i < NUM_PORTS; i++) begin
        if ((s_ctrlport_req_i[i].wr || s_ctrlport_req_i[i].rd) && !pending_q[i]) begin
          held_q[i]    <= s_ctrlport_req_i[i];
          pending_q[i] <= 1'b1;
        end
      end

      case (state_q)
        S_IDLE: begin
          if (rr_valid) begin
            grant_q    <= rr_grant_idx;
            grant_oh_q <= rr_grant_oh;
            m_req_q    <= held_q[rr_grant_idx];
            state_q    <= S_WAIT;
            busy_q     <= 1'b1;
          end
        end
        S_WAIT: begin
          // wr/rd strobe for one cycle; address/data stay for the slave.
          m_req_q.wr <= 1'b0;
          m_req_q.rd <= 1'b0;
          if (done) begin
            // The granted port cannot be capturing this cycle (it is pending),
            // so clearing its pending bit never races a capture.
            for (int i = 0; i < NUM_PORTS; i++) begin
              if (grant_oh_q[i]) begin
                s_resp_q[i]  <= done_resp;
                pending_q[i] <= 1'b0;
              end
            end
            last_grant_q <= grant_q;
            state_q      <= S_IDLE;
            busy_q       <= 1'b0;
          end
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign m_ctrlport_req_o  = m_req_q;
  assign s_ctrlport_resp_o = s_resp_q;
  assign busy_o            = busy_q;

endmodule
`default_nettype wire
